// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stall_ctrl
// Description : Central pipeline sequencer. Merges ID/EX/MEM stall requests
//               into the per-stage hold vector, sequences multi-cycle EX ops,
//               tracks the MEM data-bus wait with a timeout, and issues a
//               one-cycle flush after an exception or bus timeout.
// Ports       : clk, rst (async, active-low)
//               stallreq_id            - ID load-use hazard
//               ex_mc_start/ex_mc_len  - start of multi-cycle EX op + length
//               mem_req/mem_ack        - MEM data-bus handshake
//               excp_i                 - exception in MEM
//               stall[5:0]             - hold per stage ([0]pc .. [5]wb)
//               flush                  - clear all pipeline registers
//               mc_cnt/mc_done         - EX iteration index / result valid
//               mem_tmo_err            - MEM wait timed out
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stall_ctrl #(
    parameter int MC_W    = 6,
    parameter int MEM_TMO = 16,
    parameter int TMO_W   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stallreq_id,
    input  logic            ex_mc_start,
    input  logic [MC_W-1:0] ex_mc_len,
    input  logic            mem_req,
    input  logic            mem_ack,
    input  logic            excp_i,
    output logic [5:0]      stall,
    output logic            flush,
    output logic [MC_W-1:0] mc_cnt,
    output logic            mc_done,
    output logic            mem_tmo_err
);

    typedef enum logic [0:0] {EX_IDLE  = 1'b0, EX_BUSY  = 1'b1} ex_state_t;
    typedef enum logic [0:0] {MEM_IDLE = 1'b0, MEM_WAIT = 1'b1} mem_state_t;

    localparam logic [MC_W-1:0]  c_mc_one   = MC_W'(1);
    localparam logic [MC_W-1:0]  c_mc_zero  = '0;
    localparam logic [TMO_W-1:0] c_tmo_one  = TMO_W'(1);
    // Timer holds the number of wait cycles already spent; the cycle that
    // would bring it to MEM_TMO is the timeout cycle.
    localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(MEM_TMO - 1);

    ex_state_t        r_ex_state, w_ex_state_nxt;
    mem_state_t       r_mem_state, w_mem_state_nxt;
    logic [MC_W-1:0]  r_mc_cnt, w_mc_cnt_nxt;
    logic [MC_W-1:0]  r_mc_last, w_mc_last_nxt;
    logic [TMO_W-1:0] r_tmo_cnt, w_tmo_cnt_nxt;
    logic             r_flush, w_flush_nxt;

    logic             w_mem_stall;
    logic             w_ex_stall;
    logic             w_done;
    logic             w_tmo;
    logic [MC_W-1:0]  w_cnt_out;
    logic [MC_W-1:0]  w_len_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ex_state  <= EX_IDLE;
            r_mem_state <= MEM_IDLE;
            r_mc_cnt    <= '0;
            r_mc_last   <= '0;
            r_tmo_cnt   <= '0;
            r_flush     <= 1'b0;
        end else begin
            r_ex_state  <= w_ex_state_nxt;
            r_mem_state <= w_mem_state_nxt;
            r_mc_cnt    <= w_mc_cnt_nxt;
            r_mc_last   <= w_mc_last_nxt;
            r_tmo_cnt   <= w_tmo_cnt_nxt;
            r_flush     <= w_flush_nxt;
        end
    end

    always_comb begin
        w_ex_state_nxt  = r_ex_state;
        w_mem_state_nxt = r_mem_state;
        w_mc_cnt_nxt    = r_mc_cnt;
        w_mc_last_nxt   = r_mc_last;
        w_tmo_cnt_nxt   = r_tmo_cnt;
        w_flush_nxt     = 1'b0;
        w_mem_stall     = 1'b0;
        w_ex_stall      = 1'b0;
        w_done          = 1'b0;
        w_tmo           = 1'b0;
        w_cnt_out       = '0;
        // Index of the final cycle; a zero length behaves as a one-cycle op.
        w_len_last      = (ex_mc_len == c_mc_zero) ? c_mc_zero : (ex_mc_len - c_mc_one);

        if (r_flush) begin
            // Flush cycle: every request is dropped, only a new exception
            // can schedule a further flush.
            w_ex_state_nxt  = EX_IDLE;
            w_mem_state_nxt = MEM_IDLE;
            w_mc_cnt_nxt    = '0;
            w_mc_last_nxt   = '0;
            w_tmo_cnt_nxt   = '0;
            w_flush_nxt     = excp_i;
        end else begin
            // MEM sequencer
            case (r_mem_state)
                MEM_IDLE: begin
                    if (mem_req && !mem_ack) begin
                        w_mem_stall     = 1'b1;
                        w_mem_state_nxt = MEM_WAIT;
                        w_tmo_cnt_nxt   = c_tmo_one;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ack) begin
                        w_mem_state_nxt = MEM_IDLE;
                        w_tmo_cnt_nxt   = '0;
                    end else begin
                        w_mem_stall = 1'b1;
                        if (r_tmo_cnt == c_tmo_last) begin
                            w_tmo           = 1'b1;
                            w_mem_state_nxt = MEM_IDLE;
                            w_tmo_cnt_nxt   = '0;
                        end else begin
                            w_tmo_cnt_nxt = r_tmo_cnt + c_tmo_one;
                        end
                    end
                end
                default: w_mem_state_nxt = MEM_IDLE;
            endcase

            // EX sequencer. While MEM holds the pipe the count is frozen and
            // a finishing op waits in BUSY so mc_done lands on a free cycle.
            case (r_ex_state)
                EX_IDLE: begin
                    if (ex_mc_start) begin
                        if (w_len_last == c_mc_zero) begin
                            if (w_mem_stall) begin
                                w_ex_state_nxt = EX_BUSY;
                                w_mc_cnt_nxt   = '0;
                                w_mc_last_nxt  = '0;
                            end else begin
                                w_done = 1'b1;
                            end
                        end else begin
                            w_ex_stall     = 1'b1;
                            w_ex_state_nxt = EX_BUSY;
                            w_mc_last_nxt  = w_len_last;
                            w_mc_cnt_nxt   = w_mem_stall ? c_mc_zero : c_mc_one;
                        end
                    end
                end
                EX_BUSY: begin
                    w_cnt_out = r_mc_cnt;
                    if (r_mc_cnt == r_mc_last) begin
                        if (!w_mem_stall) begin
                            w_done         = 1'b1;
                            w_ex_state_nxt = EX_IDLE;
                            w_mc_cnt_nxt   = '0;
                        end
                    end else begin
                        w_ex_stall = 1'b1;
                        if (!w_mem_stall) begin
                            w_mc_cnt_nxt = r_mc_cnt + c_mc_one;
                        end
                    end
                end
                default: w_ex_state_nxt = EX_IDLE;
            endcase

            // A timeout is handled exactly like an exception.
            w_flush_nxt = excp_i | w_tmo;
            if (w_flush_nxt) begin
                w_ex_state_nxt  = EX_IDLE;
                w_mem_state_nxt = MEM_IDLE;
                w_mc_cnt_nxt    = '0;
                w_mc_last_nxt   = '0;
                w_tmo_cnt_nxt   = '0;
            end
        end
    end

    // Outputs are forced low while reset is asserted so that same-cycle
    // requests cannot leak through the combinational path.
    always_comb begin
        stall       = 6'b000000;
        flush       = 1'b0;
        mc_cnt      = '0;
        mc_done     = 1'b0;
        mem_tmo_err = 1'b0;
        if (rst) begin
            flush       = r_flush;
            mc_cnt      = w_cnt_out;
            mc_done     = w_done;
            mem_tmo_err = w_tmo;
            if (!r_flush) begin
                if (w_mem_stall)      stall = 6'b011111;
                else if (w_ex_stall)  stall = 6'b001111;
                else if (stallreq_id) stall = 6'b000111;
            end
        end
    end

endmodule
`default_nettype wire
